// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream mux, fixed-select or round-robin, registered output
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             accept;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_ch;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] grant_data;

  // The output stage can take a new word when empty or when it is being drained.
  assign accept = !out_valid_q || out_ready;

  // Grant decision: fixed channel in mode 0, first valid after ptr (wrapping) in mode 1.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    if (!mode) begin
      if ((int'(sel) < CH) && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant_ch  = sel;
      end
    end else begin
      for (int k = 1; k <= CH; k++) begin
        cand = SEL_W'((int'(ptr_q) + k) % CH);
        if (!grant_vld && in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_ch  = cand;
        end
      end
    end
  end

  // Select the granted channel's data word.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_ch == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the granted channel, and only when the output stage accepts.
  always_comb begin
    in_ready = '0;
    if (rst_n && accept && grant_vld) begin
      for (int i = 0; i < CH; i++) begin
        in_ready[i] = (grant_ch == SEL_W'(i));
      end
    end
  end

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      if (grant_vld) begin
        out_data_d  = grant_data;
        out_ch_d    = grant_ch;
        out_valid_d = 1'b1;
        ptr_d       = grant_ch;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset parks the pointer on the last channel so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr (CH=4 and CH=3 instances)
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        out_ready;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;

  wire  [2:0]  in_valid3 = in_valid[2:0];
  wire  [23:0] in_data3  = in_data[23:0];

  wire  [3:0]  in_ready4;
  wire  [7:0]  out_data4;
  wire  [1:0]  out_ch4;
  wire         out_valid4;
  wire  [2:0]  in_ready3;
  wire  [7:0]  out_data3;
  wire  [1:0]  out_ch3;
  wire         out_valid3;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = 4-channel, index 1 = 3-channel
  int mv[2], md[2], mch[2], mptr[2];

  int e4_rr[6] = '{0, 1, 2, 3, 0, 1};
  int e3_rr[6] = '{0, 1, 2, 0, 1, 2};
  int e4_alt[4] = '{1, 3, 1, 3};

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .CH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .mode(mode), .sel(sel), .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode), .sel(sel), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nch(input int id);
    return (id == 0) ? 4 : 3;
  endfunction

  function automatic int grant(input int id);
    int n = nch(id);
    if (!mode) begin
      if (int'(sel) < n && in_valid[int'(sel)]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      int c = (mptr[id] + k) % n;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int exp_rdy(input int id);
    int g = grant(id);
    bit acc = (mv[id] == 0) || out_ready;
    if (rst_n && acc && g >= 0) return 1 << g;
    return 0;
  endfunction

  task automatic model_update();
    for (int id = 0; id < 2; id++) begin
      int g = grant(id);
      bit acc = (mv[id] == 0) || out_ready;
      if (!rst_n) begin
        mv[id] = 0; md[id] = 0; mch[id] = 0; mptr[id] = nch(id) - 1;
      end else if (acc) begin
        if (g >= 0) begin
          mv[id] = 1; md[id] = int'(in_data[g*8 +: 8]); mch[id] = g; mptr[id] = g;
        end else begin
          mv[id] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("rdy4",  in_ready4,  exp_rdy(0));
    chk("vld4",  out_valid4, mv[0]);
    chk("data4", out_data4,  md[0]);
    chk("ch4",   out_ch4,    mch[0]);
    chk("rdy3",  in_ready3,  exp_rdy(1));
    chk("vld3",  out_valid3, mv[1]);
    chk("data3", out_data3,  md[1]);
    chk("ch3",   out_ch3,    mch[1]);
  endtask

  // one clock: compare mid-cycle against the model, then advance both past the edge
  task automatic cyc();
    #3;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b1; out_ready = 1'b1; sel = 2'd0;
    in_valid = 4'b1111; in_data = 32'h44332211;
    for (int id = 0; id < 2; id++) begin
      mv[id] = 0; md[id] = 0; mch[id] = 0; mptr[id] = nch(id) - 1;
    end
    @(posedge clk);
    model_update();
    #1;

    // reset held with all channels valid
    cyc(); cyc();
    chk("rst_vld", out_valid4, 0);
    chk("rst_data", out_data4, 0);
    chk("rst_ch", out_ch4, 0);
    chk("rst_rdy", in_ready4, 4'b0000);

    // round-robin from reset, all valid
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr4_seq", out_ch4, e4_rr[i]);
      chk("rr3_seq", out_ch3, e3_rr[i]);
      chk("rr4_vld", out_valid4, 1);
    end

    // mid-stream reset, then alternating valid pattern
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_vld", out_valid4, 0);
    rst_n = 1'b1; in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("alt4_seq", out_ch4, e4_alt[i]);
      chk("alt3_seq", out_ch3, 1);
    end

    // fixed select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
    #1 chk("fix_rdy", in_ready4, 4'b0100);
    cyc();
    chk("fix_data", out_data4, 8'h33);
    chk("fix_ch", out_ch4, 2);
    chk("fix_vld", out_valid4, 1);
    in_valid = 4'b1011;
    #1 chk("fix_norg", in_ready4, 4'b0000);
    cyc();
    chk("fix_drop", out_valid4, 0);

    // backpressure hold
    sel = 2'd1; in_valid = 4'b1111;
    cyc();
    chk("bp_load", out_data4, 8'h22);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mode = 1'($urandom); in_data = $urandom; in_valid = 4'($urandom);
      #1 chk("bp_rdy", in_ready4, 4'b0000);
      cyc();
      chk("bp_data", out_data4, 8'h22);
      chk("bp_ch", out_ch4, 1);
      chk("bp_vld", out_valid4, 1);
    end
    out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111; in_data = 32'h44332211;
    #1 chk("bp_next_rdy", in_ready4, 4'b0100);
    cyc();
    chk("bp_next_ch", out_ch4, 2);

    // mode switch 1->0 while stalled
    out_ready = 1'b0;
    cyc(); cyc();
    mode = 1'b0; sel = 2'd0;
    cyc();
    chk("sw_hold", out_data4, 8'h33);
    out_ready = 1'b1;
    cyc();
    chk("sw_ch", out_ch4, 0);
    chk("sw_data", out_data4, 8'h11);

    // sel beyond channel count on the 3-channel instance
    sel = 2'd3;
    #1 chk("sel3_rdy", in_ready3, 3'b000);
    cyc();
    chk("sel3_vld", out_valid3, 0);
    chk("sel3_ch4", out_ch4, 3);

    // 3-channel wrap after reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("wrap3_seq", out_ch3, e3_rr[i]);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 31) != 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, W-bit stream multiplexer with a registered output. It supersedes the fixed 8-bit 4:1 gate-level mux. Each input channel carries valid/ready. A mode input selects either a fixed channel (sel) or round-robin arbitration among valid channels. It sits between multiple producer blocks and one shared consumer, for example a display or UART path.

Parameters:
WIDTH, 8, data width per channel (>=1)
CH, 4, number of input channels (>=2; need not be a power of 2)
SEL_W, $clog2(CH), select/channel-index width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
in_data  in  CH*WIDTH  channel i at in_data[i*WIDTH +: WIDTH]
in_valid  in  CH  per-channel valid
in_ready  out  CH  per-channel ready (one-hot or zero)
mode  in  1  0 = fixed select, 1 = round-robin
sel  in  SEL_W  channel index used when mode=0
out_data  out  WIDTH  registered output data
out_ch  out  SEL_W  index of channel that produced out_data
out_valid  out  1  output valid
out_ready  in  1  downstream ready

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=CH-1, so the first RR search starts at channel 0.
  - in_ready is 0 while rst_n=0.
- accept = !out_valid || out_ready. This is combinational and defines one output register stage.
- Grant g, computed combinationally each cycle:
  - mode=0: g=sel if sel<CH and in_valid[sel]=1; otherwise no grant. Other channels are never granted, even if valid. sel>=CH never grants.
  - mode=1: g is the first channel with in_valid=1, searching ptr+1, ptr+2, … with wrap modulo CH. If no channel is valid, there is no grant.
- in_ready[g]=accept when a grant exists. All other in_ready bits are 0. in_ready is never asserted to a channel with in_valid=0.
- On a clk edge with accept=1:
  - With a grant: out_data<=in_data[g], out_ch<=g, out_valid<=1, ptr<=g (ptr updates in both modes).
  - With no grant: out_valid<=0. out_data, out_ch and ptr hold.
- On a clk edge with accept=0 (out_valid=1, out_ready=0): out_data, out_ch, out_valid and ptr hold. in_ready=0.
- Latency and throughput:
  - Input handshake to out_valid is 1 cycle.
  - Sustained throughput is 1 word/cycle when out_ready=1.
- in_ready depends combinationally on out_ready. This is an accepted path; there is no skid buffer.
- mode/sel changes take effect on the next grant decision. A held output word is never altered or dropped.
- Fairness: in mode 1 with all CH channels continuously valid and out_ready=1, grants cycle 0,1,…,CH-1,0. No channel waits more than CH-1 transfers.
- Synchronous reset mid-stream discards any held word: out_valid=0 next cycle and the pointer is restored to CH-1.
- No X on outputs after the first reset edge. Data are unsigned bit vectors; no arithmetic on data.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0000; then with mode=1 the first grant is ch0.
- Fixed mode: CH=4, WIDTH=8, mode=0, sel=2, in_valid=1111, data ch0..3=0x11,0x22,0x33,0x44, out_ready=1 → in_ready=0100; next cycle out_data=0x33, out_ch=2, out_valid=1. With sel=2 and in_valid[2]=0 → in_ready=0000 and out_valid drops to 0 next cycle.
- Round-robin: mode=1, in_valid=1111, out_ready=1 for 6 cycles → out_ch sequence 0,1,2,3,0,1. With in_valid=1010 → sequence 1,3,1,3.
- Backpressure: out_valid=1 with out_data=0x22, out_ready=0 for 3 cycles while inputs change → out_data stays 0x22, out_ch and ptr hold, in_ready=0000. When out_ready=1, the next grant follows the held pointer.
- Non-power-of-2: CH=3, mode=0, sel=3 → never grants. mode=1 with all valid → out_ch sequence 0,1,2,0 (wrap at 3).
- Mid-stream reset plus mode switch: reset asserted with out_valid=1 → out_valid=0 next cycle, and the first RR grant after release is ch0. Switching mode 1→0 while stalled keeps the held word; the new mode is used at the next accept.
